// File: rtl/pes_piso_arb.sv
// Round-robin scheduler that shares one LSB-first PISO serializer between NREQ requesters.
// It drives the PISO load strobe and word, and frames the serial stream with registered qualifiers.
module pes_piso_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           ack,
    output logic                      piso_load,
    output logic [WIDTH-1:0]          piso_data,
    output logic                      frame_valid,
    output logic                      frame_first,
    output logic                      frame_last,
    output logic [$clog2(NREQ)-1:0]   frame_src,
    output logic                      busy
);

    localparam int SRC_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [SRC_W-1:0] cur_src;
    logic [SRC_W-1:0] ptr;

    logic             found;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] winner_next;
    logic             arb_slot;
    logic             grant;

    // Search starts at ptr and wraps modulo NREQ, so the last winner is checked last.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[SRC_W'(idx)]) begin
                found  = 1'b1;
                winner = SRC_W'(idx);
            end
        end
    end

    assign winner_next = (winner == SRC_W'(NREQ - 1)) ? '0 : winner + 1'b1;

    // Arbitrate while idle or on the last bit, so the next word loads on the edge shifting out that bit.
    assign arb_slot = (state == ST_IDLE) || (cnt == CNT_LAST);
    assign grant    = arb_slot && found && !rst;

    always_comb begin
        ack       = '0;
        piso_data = '0;
        piso_load = 1'b1;
        if (grant) begin
            ack       = NREQ'(1) << winner;
            piso_data = req_data[winner*WIDTH +: WIDTH];
            piso_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cur_src <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state   <= ST_SHIFT;
                        cnt     <= '0;
                        cur_src <= winner;
                        ptr     <= winner_next;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (grant) begin
                        cnt     <= '0;
                        cur_src <= winner;
                        ptr     <= winner_next;
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Qualifiers decode only registered state so they line up cleanly with the PISO output bit.
    assign frame_valid = (state == ST_SHIFT);
    assign frame_first = frame_valid && (cnt == '0);
    assign frame_last  = frame_valid && (cnt == CNT_LAST);
    assign frame_src   = frame_valid ? cur_src : '0;
    assign busy        = frame_valid;

endmodule

// File: tb/tb_pes_piso_arb.sv
// Self-checking bench for pes_piso_arb: a frame-queue model checks every cycle,
// and directed sequences pin hand-computed values.
module tb_pes_piso_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  ack;
    logic        piso_load;
    logic [3:0]  piso_data;
    logic        frame_valid;
    logic        frame_first;
    logic        frame_last;
    logic [1:0]  frame_src;
    logic        busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    pes_piso_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .piso_load   (piso_load),
        .piso_data   (piso_data),
        .frame_valid (frame_valid),
        .frame_first (frame_first),
        .frame_last  (frame_last),
        .frame_src   (frame_src),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the external PISO: active-low load, shift right, serial out is bit 0.
    logic [3:0] piso_reg = 4'b0;
    always @(posedge clk) begin
        if (!piso_load) piso_reg <= piso_data;
        else            piso_reg <= piso_reg >> 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared = n_compared + 1;
        if (actual !== expected) begin
            n_mismatched = n_mismatched + 1;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst      = r;
        req      = rq;
        req_data = d;
        #2;
    endtask

    // Model: a queue holding the bits still to appear on the wire, one entry per cycle.
    typedef struct {
        logic b;
        logic f;
        logic l;
        int   src;
    } wire_t;

    wire_t q[$];
    int    m_ptr = 0;

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int         w;
        logic [3:0] exp_ack;
        logic [3:0] exp_word;
        wire_t      e;
        w        = -1;
        exp_ack  = '0;
        exp_word = '0;
        if (q.size() <= 1 && !rst) w = rr_pick(req, m_ptr);
        if (w >= 0) begin
            exp_ack[w] = 1'b1;
            exp_word   = req_data[w*WIDTH +: WIDTH];
        end
        checkOutput("ack", ack, exp_ack);
        checkOutput("piso_load", piso_load, (w < 0));
        checkOutput("piso_data", piso_data, exp_word);
        if (q.size() > 0) begin
            e = q[0];
            checkOutput("frame_valid", frame_valid, 1);
            checkOutput("busy", busy, 1);
            checkOutput("frame_first", frame_first, e.f);
            checkOutput("frame_last", frame_last, e.l);
            checkOutput("frame_src", frame_src, e.src);
            checkOutput("serial", piso_reg[0], e.b);
        end else begin
            checkOutput("frame_valid", frame_valid, 0);
            checkOutput("busy", busy, 0);
            checkOutput("frame_first", frame_first, 0);
            checkOutput("frame_last", frame_last, 0);
            checkOutput("frame_src", frame_src, 0);
        end
        if (rst) begin
            q.delete();
            m_ptr = 0;
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (w >= 0) begin
                for (int i = 0; i < WIDTH; i++) begin
                    e.b   = exp_word[i];
                    e.f   = (i == 0);
                    e.l   = (i == WIDTH - 1);
                    e.src = w;
                    q.push_back(e);
                end
                m_ptr = (w + 1) % NREQ;
            end
        end
    end

    initial begin
        rst      = 1'b1;
        req      = 4'b0;
        req_data = 16'h0;

        // Reset state
        applyStimulus(1'b1, 4'b0000, 16'h0000);
        checkOutput("rst_ack", ack, 4'b0000);
        checkOutput("rst_load", piso_load, 1);
        checkOutput("rst_data", piso_data, 4'h0);
        checkOutput("rst_valid", frame_valid, 0);
        applyStimulus(1'b1, 4'b0000, 16'h0000);

        // Single request, word 1011 goes out 1,1,0,1
        applyStimulus(1'b0, 4'b0001, 16'h000B);
        checkOutput("single_ack", ack, 4'b0001);
        checkOutput("single_load", piso_load, 0);
        checkOutput("single_data", piso_data, 4'hB);
        applyStimulus(1'b0, 4'b0000, 16'h000B);
        checkOutput("single_first", frame_first, 1);
        checkOutput("single_bit0", piso_reg[0], 1);
        checkOutput("single_src", frame_src, 0);
        applyStimulus(1'b0, 4'b0000, 16'h000B);
        checkOutput("single_bit1", piso_reg[0], 1);
        applyStimulus(1'b0, 4'b0000, 16'h000B);
        checkOutput("single_bit2", piso_reg[0], 0);
        applyStimulus(1'b0, 4'b0000, 16'h000B);
        checkOutput("single_bit3", piso_reg[0], 1);
        checkOutput("single_last", frame_last, 1);
        applyStimulus(1'b0, 4'b0000, 16'h000B);
        checkOutput("single_idle", frame_valid, 0);

        // All four requesting continuously; pointer is at 1 after the single grant
        for (int f = 0; f < 8; f++) begin
            applyStimulus(1'b0, 4'b1111, 16'h8421);
            checkOutput("rr_ack", ack, 32'(1) << ((1 + f) % 4));
            for (int c = 0; c < 3; c++) begin
                applyStimulus(1'b0, 4'b1111, 16'h8421);
                checkOutput("rr_nogap", frame_valid, 1);
            end
        end
        applyStimulus(1'b0, 4'b0000, 16'h8421);
        checkOutput("rr_end_ack", ack, 4'b0000);

        // Fairness after wrap: grant 2 leaves ptr=3, then req=0101 goes to 0 before 2
        applyStimulus(1'b0, 4'b0100, 16'h8421);
        checkOutput("wrap_ack2", ack, 4'b0100);
        repeat (3) applyStimulus(1'b0, 4'b0000, 16'h8421);
        applyStimulus(1'b0, 4'b0101, 16'h8421);
        checkOutput("wrap_ack0", ack, 4'b0001);
        repeat (3) applyStimulus(1'b0, 4'b0100, 16'h8421);
        applyStimulus(1'b0, 4'b0100, 16'h8421);
        checkOutput("wrap_ack2b", ack, 4'b0100);
        repeat (3) applyStimulus(1'b0, 4'b0000, 16'h8421);
        applyStimulus(1'b0, 4'b0000, 16'h8421);

        // Late request rising at cnt=1 is held off until the last-bit cycle
        applyStimulus(1'b0, 4'b0001, 16'h8421);
        checkOutput("late_ack0", ack, 4'b0001);
        applyStimulus(1'b0, 4'b0000, 16'h8421);
        applyStimulus(1'b0, 4'b0010, 16'h8421);
        checkOutput("late_hold1", ack, 4'b0000);
        applyStimulus(1'b0, 4'b0010, 16'h8421);
        checkOutput("late_hold2", ack, 4'b0000);
        applyStimulus(1'b0, 4'b0010, 16'h8421);
        checkOutput("late_ack1", ack, 4'b0010);
        checkOutput("late_last", frame_last, 1);
        applyStimulus(1'b0, 4'b0000, 16'h8421);
        checkOutput("late_first", frame_first, 1);
        checkOutput("late_src", frame_src, 1);
        repeat (3) applyStimulus(1'b0, 4'b0000, 16'h8421);

        // Reset mid-frame at cnt=2, requester 3 waiting
        applyStimulus(1'b0, 4'b0001, 16'h8421);
        checkOutput("mid_ack0", ack, 4'b0001);
        applyStimulus(1'b0, 4'b0000, 16'h8421);
        applyStimulus(1'b0, 4'b0000, 16'h8421);
        applyStimulus(1'b1, 4'b1000, 16'h8421);
        checkOutput("mid_rst_ack", ack, 4'b0000);
        checkOutput("mid_rst_load", piso_load, 1);
        applyStimulus(1'b0, 4'b1000, 16'h8421);
        checkOutput("mid_valid", frame_valid, 0);
        checkOutput("mid_ack3", ack, 4'b1000);
        applyStimulus(1'b0, 4'b0000, 16'h8421);
        checkOutput("mid_src", frame_src, 3);
        checkOutput("mid_bit0", piso_reg[0], 0);
        repeat (4) applyStimulus(1'b0, 4'b0000, 16'h8421);

        // Idle stability
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 4'b0000, 16'h8421);
            checkOutput("idle_load", piso_load, 1);
            checkOutput("idle_ack", ack, 4'b0000);
            checkOutput("idle_valid", frame_valid, 0);
        end

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
